// File: rtl/f_fetch_unit_pkg.sv
// Shared types and constants for the fetch unit: FSM states, redirect target selects,
// default reset/exception vectors and the fetch-address legality check.
package f_fetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] F_ADDR_HI    = 32'h0000_6FFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    typedef enum logic [2:0] {
        TSEL_SEQ,
        TSEL_EXC,
        TSEL_ERET,
        TSEL_BR,
        TSEL_J,
        TSEL_JR
    } tsel_t;

    function automatic logic fetch_addr_ok(input logic [31:0] a, input logic [31:0] lo);
        return (a[1:0] == 2'b00) && (a >= lo) && (a <= F_ADDR_HI);
    endfunction

endpackage

// File: rtl/f_fetch_unit_if.sv
// Single-outstanding request/acknowledge instruction-memory port.
interface f_fetch_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/f_npc_sel.sv
// Combinational priority redirect-target selection for the fetch unit:
// req > eret > taken branch/link > jump > jr > sequential.
module f_npc_sel
    import f_fetch_unit_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(DEF_EXC_VEC)
) (
    input  logic             stall,
    input  logic             req,
    input  logic             eret,
    input  logic             branch,
    input  logic             jump,
    input  logic             jr,
    input  logic             D_branch_link,
    input  logic             cmp_result,
    input  logic [WIDTH-1:0] D_pc,
    input  logic [25:0]      D_imm26,
    input  logic [WIDTH-1:0] FW_D_rs,
    input  logic [WIDTH-1:0] EPC,
    output logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] ds_pc,
    output logic             exc_redirect,
    output logic             br_redirect
);

    tsel_t            tsel;
    logic [WIDTH-1:0] br_off;

    assign ds_pc  = D_pc + WIDTH'(4);
    assign br_off = {{(WIDTH-18){D_imm26[15]}}, D_imm26[15:0], 2'b00};

    always_comb begin
        tsel = TSEL_SEQ;
        if (req)                                    tsel = TSEL_EXC;
        else if (eret)                              tsel = TSEL_ERET;
        else if ((branch | D_branch_link) & cmp_result) tsel = TSEL_BR;
        else if (jump)                              tsel = TSEL_J;
        else if (jr)                                tsel = TSEL_JR;
    end

    always_comb begin
        target = ds_pc;
        unique case (tsel)
            TSEL_EXC:  target = EXC_VEC;
            TSEL_ERET: target = EPC;
            TSEL_BR:   target = ds_pc + br_off;
            TSEL_J:    target = {D_pc[WIDTH-1:28], D_imm26, 2'b00};
            TSEL_JR:   target = FW_D_rs;
            default:   target = ds_pc;
        endcase
    end

    assign exc_redirect = (tsel == TSEL_EXC) || (tsel == TSEL_ERET);
    assign br_redirect  = !stall && ((tsel == TSEL_BR) || (tsel == TSEL_J) || (tsel == TSEL_JR));

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: PC/issue register, single-outstanding imem port, F output slot with
// stall skid buffer, delay-slot aware redirects. Optional feature macro: F_ADDR_CHECK_EN.
module f_fetch_unit
    import f_fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(DEF_EXC_VEC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [WIDTH-1:0] D_pc,
    input  logic [25:0]      D_imm26,
    input  logic [WIDTH-1:0] FW_D_rs,
    input  logic             branch,
    input  logic             jump,
    input  logic             jr,
    input  logic             D_branch_link,
    input  logic             cmp_result,
    input  logic             req,
    input  logic             eret,
    input  logic [WIDTH-1:0] EPC,
    f_fetch_unit_if.master   imem,
    output logic [WIDTH-1:0] F_pc,
    output logic [31:0]      F_instr,
    output logic             F_valid
`ifdef F_ADDR_CHECK_EN
    ,
    output logic             F_exc_adel
`endif
);

    state_t           state;
    logic [WIDTH-1:0] nxt;
    logic             kill;
    logic [WIDTH-1:0] hold_pc;
    logic [31:0]      hold_instr;
    logic             bad_r;

    logic [WIDTH-1:0] target, ds_pc, launch_addr;
    logic             exc, br, resp, slot_free, ds_in_f, launch_ok;
    logic [31:0]      resp_data;
    logic             launch, f_load, f_from_hold, f_clear, hold_load;
    logic             kill_set, kill_clr, nxt_load;

    f_npc_sel #(.WIDTH(WIDTH), .EXC_VEC(EXC_VEC)) u_npc_sel (
        .stall        (stall),
        .req          (req),
        .eret         (eret),
        .branch       (branch),
        .jump         (jump),
        .jr           (jr),
        .D_branch_link(D_branch_link),
        .cmp_result   (cmp_result),
        .D_pc         (D_pc),
        .D_imm26      (D_imm26),
        .FW_D_rs      (FW_D_rs),
        .EPC          (EPC),
        .target       (target),
        .ds_pc        (ds_pc),
        .exc_redirect (exc),
        .br_redirect  (br)
    );

`ifdef F_ADDR_CHECK_EN
    logic hold_adel;
    assign launch_ok = fetch_addr_ok(32'(launch_addr), 32'(RESET_PC));
`else
    assign launch_ok = 1'b1;
`endif

    // An illegal fetch address completes immediately as a zero instruction, no bus cycle.
    assign resp      = (state == ISSUE) && (bad_r || imem.imem_ack);
    assign resp_data = bad_r ? '0 : imem.imem_rdata;
    assign slot_free = !F_valid || !stall;
    assign ds_in_f   = F_valid && (F_pc == ds_pc);

    always_comb begin
        launch      = 1'b0;
        launch_addr = nxt;
        f_load      = 1'b0;
        f_from_hold = 1'b0;
        f_clear     = 1'b0;
        hold_load   = 1'b0;
        kill_set    = 1'b0;
        kill_clr    = 1'b0;
        nxt_load    = 1'b0;
        unique case (state)
            IDLE: begin
                launch      = 1'b1;
                launch_addr = exc ? target : RESET_PC;
            end
            HOLD: begin
                if (exc) begin
                    f_clear     = 1'b1;
                    launch      = 1'b1;
                    launch_addr = target;
                end else if (!stall) begin
                    launch      = 1'b1;
                    launch_addr = br ? target : nxt;
                    // Delay slot leaving F makes the buffered word a wrong-path fetch.
                    if (br && ds_in_f) f_clear = 1'b1;
                    else begin
                        f_load      = 1'b1;
                        f_from_hold = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (exc) begin
                    f_clear = 1'b1;
                    if (resp) begin
                        launch      = 1'b1;
                        launch_addr = target;
                        kill_clr    = 1'b1;
                    end else begin
                        kill_set = 1'b1;
                        nxt_load = 1'b1;
                    end
                end else if (kill) begin
                    if (!stall) f_clear = 1'b1;
                    if (resp) begin
                        launch      = 1'b1;
                        launch_addr = br ? target : nxt;
                        kill_clr    = 1'b1;
                    end else if (br) nxt_load = 1'b1;
                end else if (br && ds_in_f) begin
                    f_clear = 1'b1;
                    if (resp) begin
                        launch      = 1'b1;
                        launch_addr = target;
                    end else begin
                        kill_set = 1'b1;
                        nxt_load = 1'b1;
                    end
                end else if (br) begin
                    // Delay slot is the in-flight fetch: let it land, then go to target.
                    if (resp) begin
                        f_load      = 1'b1;
                        launch      = 1'b1;
                        launch_addr = target;
                    end else begin
                        f_clear  = 1'b1;
                        nxt_load = 1'b1;
                    end
                end else if (resp) begin
                    if (slot_free) begin
                        f_load = 1'b1;
                        launch = 1'b1;
                    end else hold_load = 1'b1;
                end else if (!stall) f_clear = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= RESET_PC;
            nxt            <= RESET_PC;
            kill           <= 1'b0;
            bad_r          <= 1'b0;
            hold_pc        <= '0;
            hold_instr     <= '0;
            F_pc           <= RESET_PC;
            F_instr        <= '0;
            F_valid        <= 1'b0;
`ifdef F_ADDR_CHECK_EN
            hold_adel      <= 1'b0;
            F_exc_adel     <= 1'b0;
`endif
        end else begin
            if (launch) begin
                state          <= ISSUE;
                imem.imem_req  <= launch_ok;
                imem.imem_addr <= launch_addr;
                nxt            <= launch_addr + WIDTH'(4);
                bad_r          <= !launch_ok;
            end else if (hold_load) begin
                state         <= HOLD;
                imem.imem_req <= 1'b0;
            end
            if (nxt_load) nxt <= target;
            if (kill_set)      kill <= 1'b1;
            else if (kill_clr) kill <= 1'b0;
            if (hold_load) begin
                hold_pc    <= imem.imem_addr;
                hold_instr <= resp_data;
            end
            if (f_load) begin
                F_pc    <= f_from_hold ? hold_pc : imem.imem_addr;
                F_instr <= f_from_hold ? hold_instr : resp_data;
                F_valid <= 1'b1;
            end else if (f_clear) begin
                F_valid <= 1'b0;
            end
`ifdef F_ADDR_CHECK_EN
            if (hold_load) hold_adel <= bad_r;
            if (f_load)       F_exc_adel <= f_from_hold ? hold_adel : bad_r;
            else if (f_clear) F_exc_adel <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed self-checking bench for f_fetch_unit with a variable-latency memory model
// (instruction word = ~address). Honours F_ADDR_CHECK_EN.
module tb_f_fetch_unit;
    import f_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [31:0] D_pc, FW_D_rs, EPC;
    logic [25:0] D_imm26;
    logic        branch, jump, jr, D_branch_link, cmp_result, req, eret;
    logic [31:0] F_pc, F_instr;
    logic        F_valid;
`ifdef F_ADDR_CHECK_EN
    logic        F_exc_adel;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned lat   = 0;
    int unsigned wcnt  = 0;

    always #5 clk = ~clk;

    f_fetch_unit_if #(.WIDTH(32)) mif ();

    assign mif.imem_ack   = mif.imem_req && (wcnt >= lat);
    assign mif.imem_rdata = ~mif.imem_addr;

    always @(posedge clk) begin
        if (reset || !mif.imem_req || mif.imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    f_fetch_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .D_pc         (D_pc),
        .D_imm26      (D_imm26),
        .FW_D_rs      (FW_D_rs),
        .branch       (branch),
        .jump         (jump),
        .jr           (jr),
        .D_branch_link(D_branch_link),
        .cmp_result   (cmp_result),
        .req          (req),
        .eret         (eret),
        .EPC          (EPC),
        .imem         (mif),
        .F_pc         (F_pc),
        .F_instr      (F_instr),
        .F_valid      (F_valid)
`ifdef F_ADDR_CHECK_EN
        ,
        .F_exc_adel   (F_exc_adel)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        stall = 0; D_pc = '0; D_imm26 = '0; FW_D_rs = '0; EPC = '0;
        branch = 0; jump = 0; jr = 0; D_branch_link = 0; cmp_result = 0;
        req = 0; eret = 0;
    endtask

    task automatic do_reset(input int unsigned l);
        reset = 1;
        lat   = l;
        clear_d();
        tick();
        tick();
    endtask

    initial begin
        // ---- reset and zero-latency streaming ----
        do_reset(0);
        chk("rst_req", mif.imem_req, 0);
        chk("rst_addr", mif.imem_addr, 32'h3000);
        chk("rst_fpc", F_pc, 32'h3000);
        chk("rst_finstr", F_instr, 0);
        chk("rst_fvalid", F_valid, 0);
`ifdef F_ADDR_CHECK_EN
        chk("rst_adel", F_exc_adel, 0);
`endif
        reset = 0;
        tick(); // c1
        chk("c1_req", mif.imem_req, 1);
        chk("c1_addr", mif.imem_addr, 32'h3000);
        chk("c1_fvalid", F_valid, 0);
        tick(); // c2
        chk("c2_addr", mif.imem_addr, 32'h3004);
        chk("c2_fvalid", F_valid, 1);
        chk("c2_fpc", F_pc, 32'h3000);
        chk("c2_finstr", F_instr, ~32'h0000_3000);
        tick(); // c3
        chk("c3_addr", mif.imem_addr, 32'h3008);
        chk("c3_fpc", F_pc, 32'h3004);

        // ---- taken beq at 0x3000, delay slot already in F ----
        D_pc = 32'h3000; D_imm26 = 26'd4; branch = 1; cmp_result = 1;
        tick(); // c4
        clear_d();
        chk("br0_addr", mif.imem_addr, 32'h3014);
        chk("br0_fvalid", F_valid, 0);
        tick(); // c5
        chk("br0_tgt_fpc", F_pc, 32'h3014);
        chk("br0_tgt_finstr", F_instr, ~32'h0000_3014);
        chk("br0_tgt_fvalid", F_valid, 1);
        chk("br0_next_addr", mif.imem_addr, 32'h3018);
        tick(); // c6
        chk("j_pre_fpc", F_pc, 32'h3018);
        D_pc = 32'h3014; D_imm26 = 26'h0000C40; jump = 1;
        tick(); // c7
        clear_d();
        chk("j_addr", mif.imem_addr, 32'h3100);
        chk("j_fvalid", F_valid, 0);
        tick(); // c8
        tick(); // c9
        chk("prio_pre_fpc", F_pc, 32'h3104);
        // not-taken branch, jump and jr together: jump must win
        D_pc = 32'h3100; D_imm26 = 26'h0000C80; branch = 1; cmp_result = 0;
        jump = 1; jr = 1; FW_D_rs = 32'h3300;
        tick(); // c10
        clear_d();
        chk("prio_addr", mif.imem_addr, 32'h3200);

        // ---- same branch, latency 3, delay slot in flight ----
        do_reset(3);
        reset = 0;
        for (int i = 0; i < 5; i++) tick(); // c1..c5
        chk("l3_fpc", F_pc, 32'h3000);
        chk("l3_addr", mif.imem_addr, 32'h3004);
        D_pc = 32'h3000; D_imm26 = 26'd4; branch = 1; cmp_result = 1;
        tick(); // c6
        clear_d();
        chk("l3_ds_req", mif.imem_req, 1);
        chk("l3_ds_addr", mif.imem_addr, 32'h3004);
        chk("l3_fvalid", F_valid, 0);
        tick(); tick(); tick(); // c9
        chk("l3_ds_fpc", F_pc, 32'h3004);
        chk("l3_ds_fvalid", F_valid, 1);
        chk("l3_tgt_addr", mif.imem_addr, 32'h3014);

        // ---- stall with full F slot ----
        do_reset(0);
        reset = 0;
        tick(); tick(); tick(); // c3
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            tick(); // c4..c8
            chk("st_req", mif.imem_req, 0);
            chk("st_fpc", F_pc, 32'h3004);
            chk("st_finstr", F_instr, ~32'h0000_3004);
            chk("st_fvalid", F_valid, 1);
        end
        stall = 0;
        tick(); // c9
        chk("st_rel_fpc", F_pc, 32'h3008);
        chk("st_rel_req", mif.imem_req, 1);
        chk("st_rel_addr", mif.imem_addr, 32'h300C);

        // ---- exception during outstanding fetch, latency 2 ----
        do_reset(2);
        reset = 0;
        for (int i = 0; i < 4; i++) tick(); // c4
        chk("ex_pre_fpc", F_pc, 32'h3000);
        chk("ex_pre_fvalid", F_valid, 1);
        req = 1;
        tick(); // c5
        req = 0;
        chk("ex_fvalid", F_valid, 0);
        chk("ex_hold_addr", mif.imem_addr, 32'h3004);
        tick(); // c6, killed ack arrives
        tick(); // c7
        chk("ex_fvalid2", F_valid, 0);
        chk("ex_addr", mif.imem_addr, 32'h4180);
        tick(); tick(); tick(); // c10
        chk("ex_fpc", F_pc, 32'h4180);
        req = 1; eret = 1; EPC = 32'h5000;
        tick(); // c11
        clear_d();
        chk("rqer_fvalid", F_valid, 0);
        tick(); tick(); // c13
        chk("rqer_addr", mif.imem_addr, 32'h4180);
        chk("rqer_fvalid2", F_valid, 0);
        // eret honoured while stalled
        eret = 1; EPC = 32'h3100; stall = 1;
        tick(); // c14
        clear_d();
        tick(); tick(); // c16
        chk("eret_addr", mif.imem_addr, 32'h3100);

`ifdef F_ADDR_CHECK_EN
        // ---- misaligned jr target ----
        do_reset(0);
        reset = 0;
        tick(); tick(); tick(); // c3
        D_pc = 32'h3000; jr = 1; FW_D_rs = 32'h3002;
        tick(); // c4
        clear_d();
        chk("adel_req0", mif.imem_req, 0);
        chk("adel_fvalid0", F_valid, 0);
        tick(); // c5
        chk("adel_req1", mif.imem_req, 0);
        chk("adel_fpc", F_pc, 32'h3002);
        chk("adel_finstr", F_instr, 0);
        chk("adel_flag", F_exc_adel, 1);
        chk("adel_fvalid", F_valid, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
